sobel_window_fetch: RTL

SOBEL_WINDOW_FETCH -- requirements
Module: sobel_window_fetch

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/window_addr_gen.sv | 58 +++++
 rtl/sobel_window_fetch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window fetcher.
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 8;
    localparam int WIN_W  = 72;
    localparam int ROW_W  = 3 * PIX_W;

    // Encoding of the last centre move reported alongside move_done.
    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    // Fetch flavour; move modes share their encoding with the direction
    // input so a move request maps onto a mode by a plain cast.
    typedef enum logic [1:0] {
        MODE_FILL  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_DOWN  = 2'b11
    } fetch_mode_t;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/window_addr_gen.sv
// Maps (centre, pitch, mode, read index) to the 8-bit pixel address to read.
module window_addr_gen
    import sobel_pkg::*;
(
    input  logic [ADDR_W-1:0] centre,
    input  logic [ADDR_W-1:0] pitch,
    input  fetch_mode_t       mode,
    input  logic [3:0]        idx,
    output logic [ADDR_W-1:0] addr
);

    logic [1:0]        row;
    logic [1:0]        col;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] col_off;

    // Pick the window cell for this read, then offset from the centre mod 256.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        row = 2'd1;
        col = 2'd1;
        case (mode)
            MODE_FILL: begin
                row = 2'(idx / 4'd3);
                col = 2'(idx % 4'd3);
            end
            MODE_RIGHT: begin
                row = idx[1:0];
                col = 2'd2;
            end
            MODE_LEFT: begin
                row = idx[1:0];
                col = 2'd0;
            end
            MODE_DOWN: begin
                row = 2'd2;
                col = idx[1:0];
            end
            default: ;
        endcase

        case (row)
            2'd0:    row_off = 8'd0 - pitch;
            2'd1:    row_off = 8'd0;
            default: row_off = pitch;
        endcase

        case (col)
            2'd0:    col_off = 8'hFF;
            2'd1:    col_off = 8'd0;
            default: col_off = 8'd1;
        endcase

        addr = centre + row_off + col_off;
    end

endmodule

// File: rtl/sobel_window_fetch.sv
// Fetches a full 3x3 pixel window, or the three new pixels after a one-step
// move, and presents the updated window with a one-cycle valid pulse.
module sobel_window_fetch
    import sobel_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              fill_start,
    input  logic              move_done,
    input  logic [1:0]        direction,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic [11:0]       length,
    input  logic              load_initial,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [WIN_W-1:0]  window,
    output logic              window_valid,
    output logic              busy,
    output logic              overrun
);

    fetch_state_t      state, state_nxt;
    fetch_mode_t       mode_q;
    logic [ADDR_W-1:0] centre_q;
    logic [ADDR_W-1:0] pitch_q;
    logic [3:0]        count_q;
    logic [3:0]        rd_idx;
    logic              cap_valid;
    logic [3:0]        cap_idx;
    pix_t              staging [9];
    pix_t              staged  [9];
    logic [WIN_W-1:0]  window_nxt;
    logic [ADDR_W-1:0] gen_addr;
    logic              req_fill, req_move, req_any, accept;
    logic              unused_length;

    // Only the low byte of the pitch matters in 8-bit address arithmetic.
    assign unused_length = &{1'b0, length[11:8]};

    assign req_fill = fill_start;
    assign req_move = move_done && (direction != DIR_NONE);
    assign req_any  = req_fill || req_move;
    assign accept   = (state == ST_IDLE) && req_any && !load_initial;

    window_addr_gen u_addr_gen (
        .centre (centre_q),
        .pitch  (pitch_q),
        .mode   (mode_q),
        .idx    (rd_idx),
        .addr   (gen_addr)
    );

    // Next-state and strobe decode; load_initial overrides everything.
    always_comb begin
        state_nxt    = state;
        mem_ren      = 1'b0;
        window_valid = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (req_any) state_nxt = ST_READ;
            ST_READ: begin
                mem_ren = 1'b1;
                if (rd_idx == count_q - 4'd1) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE: begin
                window_valid = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (load_initial) begin
            state_nxt    = ST_IDLE;
            mem_ren      = 1'b0;
            window_valid = 1'b0;
        end
        mem_raddr = mem_ren ? gen_addr : '0;
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Latch the request parameters on acceptance and step the read index.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            centre_q <= '0;
            pitch_q  <= '0;
            mode_q   <= MODE_FILL;
            count_q  <= 4'd0;
            rd_idx   <= 4'd0;
        end else if (accept) begin
            centre_q <= addr_r;
            pitch_q  <= length[7:0];
            mode_q   <= req_fill ? MODE_FILL : fetch_mode_t'(direction);
            count_q  <= req_fill ? 4'd9 : 4'd3;
            rd_idx   <= 4'd0;
        end else if (mem_ren) begin
            rd_idx   <= rd_idx + 4'd1;
        end
    end

    // Data returns one cycle after the strobe; remember which slot it fills.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cap_valid <= 1'b0;
            cap_idx   <= 4'd0;
        end else begin
            cap_valid <= mem_ren;
            cap_idx   <= rd_idx;
        end
    end

    // Staging buffer write.
    // NOTE: the staging buffer carries no reset; every slot consumed by a
    // window update is written by the same fetch before it is read.
    always_ff @(posedge clk) begin
        if (cap_valid) staging[cap_idx] <= mem_rdata;
    end

    // New window contents: staged pixels plus the pixel landing this cycle.
    always_comb begin
        staged = staging;
        if (cap_valid) staged[cap_idx] = mem_rdata;
        window_nxt = window;
        case (mode_q)
            MODE_FILL:
                window_nxt = {staged[8], staged[7], staged[6], staged[5], staged[4],
                              staged[3], staged[2], staged[1], staged[0]};
            MODE_RIGHT:
                for (int r = 0; r < 3; r++)
                    window_nxt[r*ROW_W +: ROW_W] = {staged[r],
                                                    window[r*ROW_W + 2*PIX_W +: PIX_W],
                                                    window[r*ROW_W + PIX_W +: PIX_W]};
            MODE_LEFT:
                for (int r = 0; r < 3; r++)
                    window_nxt[r*ROW_W +: ROW_W] = {window[r*ROW_W + PIX_W +: PIX_W],
                                                    window[r*ROW_W +: PIX_W],
                                                    staged[r]};
            MODE_DOWN:
                window_nxt = {staged[2], staged[1], staged[0], window[WIN_W-1:ROW_W]};
            default: ;
        endcase
    end

    // Window register: changes only on the DRAIN->DONE edge or on clear.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)               window <= '0;
        else if (load_initial)      window <= '0;
        else if (state == ST_DRAIN) window <= window_nxt;
    end

    // Sticky overrun: a request arrived while a fetch was in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)               overrun <= 1'b0;
        else if (load_initial)      overrun <= 1'b0;
        else if (busy && req_any)   overrun <= 1'b1;
    end

endmodule
